la_dump_reader: RTL and testbench

//  Read-out engine for the logic-analyzer capture buffer. On start it snapshots STATUS,

---
 rtl/la_dump_reader.sv | 130 +++++++++++++
 tb/tb_la_dump_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/la_dump_reader.sv
// rtl/la_dump_reader.sv - capture-buffer dump engine: framed byte stream (HDR, STATUS, data, XOR checksum)
module la_dump_reader #(
  parameter int          ADDR_W = 5,
  parameter int          DATA_W = 32,
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] AI,
  input  logic [DATA_W-1:0] DOUT,
  input  logic [7:0]        STATUS,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BPW   = DATA_W / 8;
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        WAIT_END  = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_STS, S_ADDR, S_WAIT, S_BYTE, S_CSUM
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   shreg;
  logic [BC_W-1:0]     byte_cnt;
  logic [1:0]          wait_cnt;
  logic [7:0]          status_q;
  logic [7:0]          csum;
  logic                xfer;

  assign xfer = tx_valid & tx_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_IDLE: if (start) state_n = S_HDR;
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR;
        if (xfer) state_n = S_STS;
      end
      S_STS: begin
        tx_valid = 1'b1;
        tx_data  = status_q;
        if (xfer) state_n = S_ADDR;
      end
      S_ADDR: state_n = S_WAIT;
      S_WAIT: if (wait_cnt == WAIT_END) state_n = S_BYTE;
      S_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = shreg[DATA_W-1 -: 8];
        if (xfer && byte_cnt == LAST_BYTE)
          state_n = (idx == LAST_IDX) ? S_CSUM : S_ADDR;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (xfer) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // abort beats any same-cycle transfer; the frame is simply truncated
    if (abort && state != S_IDLE) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      AI       <= '0;
      idx      <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      wait_cnt <= '0;
      status_q <= 8'h00;
      csum     <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          status_q <= STATUS;
          idx      <= '0;
          AI       <= '0;
          csum     <= 8'h00;
        end
        S_STS: if (xfer) csum <= csum ^ status_q;
        S_ADDR: wait_cnt <= 2'd0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == WAIT_END) begin
            shreg    <= DOUT;
            byte_cnt <= '0;
          end
        end
        S_BYTE: if (xfer) begin
          shreg    <= shreg << 8;
          csum     <= csum ^ shreg[DATA_W-1 -: 8];
          byte_cnt <= byte_cnt + 1'b1;
          // AI moves at ADDR entry so the read latency counts from there
          if (byte_cnt == LAST_BYTE && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
            AI  <= idx + 1'b1;
          end
        end
        S_CSUM: if (xfer && !abort) done <= 1'b1;
        default: ;
      endcase
      if (state != S_IDLE && state_n == S_IDLE) AI <= '0;
    end
  end

endmodule

// File: tb/tb_la_dump_reader.sv
// tb/tb_la_dump_reader.sv - randomized scoreboard bench for la_dump_reader
module tb_la_dump_reader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BPW    = DATA_W / 8;

  typedef struct { logic [7:0] b; bit last; } item_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done;
  logic [ADDR_W-1:0] AI;
  logic [DATA_W-1:0] DOUT;
  logic [7:0]        STATUS = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];
  item_t             exp_q [$];
  int                checks = 0;
  int                errors = 0;
  int                sent_cnt = 0;
  int                ready_pct = 100;
  bit                expect_done = 0;
  bit                stalled = 0;
  bit                prev_abort = 0;
  logic [7:0]        held = 8'h00;

  la_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .HDR(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .AI(AI), .DOUT(DOUT), .STATUS(STATUS), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // analyzer buffer: read data valid RD_LAT clocks after AI changes
  always @(posedge clk) begin
    pipe[0] <= mem[AI];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign DOUT = pipe[RD_LAT-1];

  initial forever begin
    @(posedge clk); #1;
    tx_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      expect_done = 0;
      stalled     = 0;
      prev_abort  = 0;
    end else begin
      check("done", done, expect_done);
      if (expect_done) check("busy_after_done", busy, 0);
      expect_done = 0;
      if (stalled && !prev_abort) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, held);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          check($sformatf("byte%0d", sent_cnt), tx_data, it.b);
          sent_cnt++;
          if (it.last) expect_done = 1;
        end
      end
      stalled    = tx_valid && !tx_ready;
      held       = tx_data;
      prev_abort = abort;
    end
  end

  task automatic push_frame();
    logic [7:0] cs;
    logic [7:0] b;
    exp_q.push_back('{8'hA5, 0});
    exp_q.push_back('{STATUS, 0});
    cs = STATUS;
    for (int i = 0; i < DEPTH; i++)
      for (int j = BPW - 1; j >= 0; j--) begin
        b  = mem[i][8*j +: 8];
        cs ^= b;
        exp_q.push_back('{b, 0});
      end
    exp_q.push_back('{cs, 1});
    sent_cnt = 0;
  endtask

  // called at posedge+1; STATUS must be stable through the accepting edge
  task automatic do_start();
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    check("dump_timeout", ok, 1);
  endtask

  task automatic wait_sent(input int cnt);
    bit ok = 0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      if (sent_cnt >= cnt && tx_valid) begin ok = 1; break; end
    end
    check("wait_sent_timeout", ok, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, tx_valid, 0);
    check({tag, "_ai"}, AI, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h01010101 * i;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  initial begin
    fill_pattern();
    #3;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // full-rate dump of the ramp pattern
    STATUS = 8'h3C; ready_pct = 100;
    do_start();
    wait_idle();

    // same frame under heavy backpressure
    ready_pct = 30;
    do_start();
    wait_idle();

    // start while busy is ignored
    ready_pct = 70;
    fill_random();
    STATUS = 8'h5A;
    do_start();
    wait_sent(40);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_idle();

    // abort on entry 7 byte 2, then a clean dump
    ready_pct = 100;
    do_start();
    wait_sent(2 + 7 * BPW + 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check_idle_outputs("abort");
    repeat (3) @(posedge clk); #1;
    check("abort_no_restart", busy, 0);
    do_start();
    wait_idle();

    // asynchronous reset mid-BYTE
    ready_pct = 80;
    do_start();
    wait_sent(50);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    exp_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_rst");
    do_start();
    wait_idle();

    // STATUS toggling after the snapshot
    ready_pct = 60;
    fill_random();
    STATUS = 8'hC3;
    do_start();
    for (int n = 0; n < 300 && busy; n++) begin
      STATUS = $urandom;
      @(posedge clk); #1;
    end
    wait_idle();

    // abort in idle is harmless; abort+start in idle accepts start
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    STATUS = 8'h81;
    abort = 1'b1;
    do_start();
    abort = 1'b0;
    check("start_with_abort_busy", busy, 1);
    // start in the done cycle is accepted
    begin
      bit seen = 0;
      for (int n = 0; n < 20000; n++) begin
        if (done) begin seen = 1; break; end
        @(posedge clk); #1;
      end
      check("done_seen", seen, 1);
    end
    STATUS = 8'h42;
    do_start();
    check("start_on_done_busy", busy, 1);
    wait_idle();

    // random dumps
    for (int r = 0; r < 4; r++) begin
      fill_random();
      STATUS    = $urandom;
      ready_pct = $urandom_range(20, 100);
      do_start();
      wait_idle();
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
